pipe_add_sub: RTL and testbench
===============================

Name: pipe_add_sub

Overview:
- Parametrised, pipelined N-bit adder/subtractor. It is the successor to the single-bit full adder cell.
- The operand is split into STAGES equal chunks. Each pipeline stage resolves one chunk and passes its carry forward in a register.
- Full valid/ready handshake with per-stage backpressure, so it can drop into streaming datapaths (ALU, accumulators, address generators).
- Adds subtract-with-borrow mode and a signed-overflow flag.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages. Chunk width CW = WIDTH/STAGES. STAGES=1 gives a single registered adder.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_1  input  WIDTH  operand A.
- in_2  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = A+B+Cin; 1 = A-B-Cin.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- Sum  output  WIDTH  result.
- Carry  output  1  raw carry-out of the MSB (in sub mode, 1 = no borrow).
- Overflow  output  1  two's-complement signed overflow.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Arithmetic:
  - B_eff = sub ? ~in_2 : in_2.
  - c0 = sub ? ~Cin : Cin.
  - {Carry, Sum} = in_1 + B_eff + c0, WIDTH+1 bits.
  - Overflow = (in_1[MSB] == B_eff[MSB]) && (Sum[MSB] != in_1[MSB]).
- Stage k (0..STAGES-1):
  - Adds chunk k of A and B_eff with the carry registered from stage k-1; stage 0 uses c0.
  - Registers the chunk sum, carry-out, already-resolved lower chunks and the still-unprocessed upper operand chunks.
  - sub is consumed at entry; B is inverted before stage 0, so sub is not carried down the pipe.
- Overflow is computed in the last stage from the registered MSBs of A and B_eff and the final sum MSB.
- Handshake:
  - Each stage holds a valid bit v[k].
  - ready[k] = !v[k] || ready[k+1], with ready[STAGES] = out_ready.
  - in_ready = ready[0], combinational from out_ready.
  - Transfer into stage 0 when in_valid && in_ready.
  - Stage k advances into k+1 when v[k] && ready[k+1].
  - out_valid = v[STAGES-1]. The last stage is dequeued on out_valid && out_ready.
- Latency: exactly STAGES cycles from accept edge to out_valid, with no stalls.
- Throughput: 1 result/cycle while out_ready is held high.
- Stall:
  - While out_valid && !out_ready, Sum/Carry/Overflow/out_valid hold stable.
  - Upstream bubbles are collapsed, so up to STAGES results can be buffered.
  - in_ready deasserts only when all stages are full and out_ready=0.
- Simultaneous events: a full pipe with out_ready=1 accepts new input in the same cycle the oldest result leaves. No loss, no duplication.
- Ordering: results exit strictly in acceptance order.
- Reset:
  - Synchronous: on any rising edge with rst=1, all v[k] clear to 0, and Sum, Carry and Overflow go to 0.
  - out_valid=0 from the following cycle. In-flight operations are discarded, including a reset asserted mid-operation.
  - in_ready is 1 once rst is deasserted; operands presented during rst are ignored.
- Data registers may be left unreset internally, but the Sum/Carry/Overflow outputs must read 0 while out_valid=0 after reset.
- No X propagation on outputs when in_valid=0.

Test Plan:
- WIDTH=8, STAGES=2:
  - Add 0xFF+0x01, Cin=0 -> Sum=0x00, Carry=1, Overflow=0.
  - out_valid rises exactly 2 cycles after accept.
- Add 0x7F+0x01 -> Sum=0x80, Carry=0, Overflow=1. Add 0x10+0x20, Cin=1 -> Sum=0x31, Carry=0, Overflow=0.
- Subtract cases:
  - sub=1, 0x05-0x03, Cin=0 -> Sum=0x02, Carry=1.
  - 0x00-0x01 -> Sum=0xFF, Carry=0, Overflow=0.
  - 0x80-0x01 -> Sum=0x7F, Carry=1, Overflow=1.
- Backpressure:
  - Stream 6 ops back-to-back with out_ready=0 -> in_ready drops after 2 accepts; Sum holds the first result.
  - Release out_ready -> all 6 results emerge in order with no gaps or duplicates.
- Reset mid-flight: assert rst for 1 cycle with 2 ops in the pipe -> out_valid=0 and Sum/Carry/Overflow=0 next cycle; the discarded results never appear.
- WIDTH=32, STAGES=4 and STAGES=1: 1000 random add/sub ops with random out_ready toggling -> all match the golden model (in_1 ± in_2 ± Cin, Carry and Overflow rules above). Latency with no stalls equals STAGES.

Source files
------------

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined WIDTH-bit adder/subtractor with valid/ready handshake.
// The operands are cut into STAGES chunks of CW bits. Stage k adds chunk k and
// passes its carry to stage k+1 in a register. Each stage has its own valid bit,
// so a stall only backs up as far as the first empty stage.
module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             Cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW  = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  // Per-stage state. a_q/b_q carry the operands forward (b already inverted for
  // subtract). r_q collects the resolved result chunks. c_q is the chunk carry.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];

  // Next values for each stage, used when that stage loads.
  logic [STAGES-1:0] c_d;
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] load;
  logic [CW:0]       chunk;
  logic              c_in;

  // Ready ripples back from the output. A stage can take data if it is empty or
  // if its own contents move on this cycle. That lets bubbles collapse.
  always_comb begin
    rdy  = '0;
    load = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
    load[0] = in_valid && rdy[0];
    for (int k = 1; k < STAGES; k++) begin
      load[k] = v_q[k-1] && rdy[k];
    end
  end

  // Pick each stage's operands. Stage 0 takes them from the ports, handling
  // subtract here: invert B and invert the borrow into a carry. Each stage then
  // adds its own chunk.
  always_comb begin
    chunk = '0;
    c_in  = 1'b0;
    c_d   = '0;

    a_d[0] = in_1;
    b_d[0] = sub ? ~in_2 : in_2;
    r_d[0] = '0;
    chunk  = {1'b0, a_d[0][CW-1:0]} + {1'b0, b_d[0][CW-1:0]} + {{CW{1'b0}}, Cin ^ sub};
    r_d[0][CW-1:0] = chunk[CW-1:0];
    c_d[0] = chunk[CW];

    for (int k = 1; k < STAGES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      r_d[k] = r_q[k-1];
      c_in   = c_q[k-1];
      chunk  = {1'b0, a_d[k][k*CW +: CW]} + {1'b0, b_d[k][k*CW +: CW]} + {{CW{1'b0}}, c_in};
      r_d[k][k*CW +: CW] = chunk[CW-1:0];
      c_d[k] = chunk[CW];
    end
  end

  // Valid bits. Reset empties the pipe and drops any operation in flight.
  // A stage sets its bit when it loads and clears it when its data moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= 1'b1;
        end else if (rdy[k+1]) begin
          v_q[k] <= 1'b0;
        end
      end
    end
  end

  // Data registers have no reset. They change only on load, so a stalled
  // result stays stable. The outputs are masked by valid, not by reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        r_q[k] <= r_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];

  // Drive the result from the last stage. Overflow is taken from the operand
  // MSBs held in that stage. Outputs read zero while no result is valid, so
  // uninitialised data never reaches the pins.
  always_comb begin
    Sum      = '0;
    Carry    = 1'b0;
    Overflow = 1'b0;
    if (v_q[STAGES-1]) begin
      Sum      = r_q[STAGES-1];
      Carry    = c_q[STAGES-1];
      Overflow = (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB]) &&
                 (r_q[STAGES-1][MSB] != a_q[STAGES-1][MSB]);
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: directed vectors on an 8-bit/2-stage instance; random streams
// with a golden model on 32-bit/4-stage and 32-bit/1-stage instances.
module tb_pipe_add_sub;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } res_t;

  logic clk;
  logic rst;

  logic [7:0]  d_in_1, d_in_2, d_sum;
  logic        d_cin, d_sub, d_in_valid, d_in_ready, d_carry, d_ovf, d_out_valid, d_out_ready;

  logic [31:0] r_a, r_b, r4_sum, r1_sum;
  logic        r_cin, r_sub;
  logic        r4_in_valid, r4_in_ready, r4_carry, r4_ovf, r4_out_valid, r4_out_ready;
  logic        r1_in_valid, r1_in_ready, r1_carry, r1_ovf, r1_out_valid, r1_out_ready;

  int checks;
  int failures;
  vec_t vecs [10];
  res_t q4 [$];
  res_t q1 [$];

  pipe_add_sub #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_1(d_in_1), .in_2(d_in_2), .Cin(d_cin), .sub(d_sub),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .Sum(d_sum), .Carry(d_carry),
    .Overflow(d_ovf), .out_valid(d_out_valid), .out_ready(d_out_ready)
  );

  pipe_add_sub #(.WIDTH(32), .STAGES(4)) u_dut32s4 (
    .clk(clk), .rst(rst), .in_1(r_a), .in_2(r_b), .Cin(r_cin), .sub(r_sub),
    .in_valid(r4_in_valid), .in_ready(r4_in_ready), .Sum(r4_sum), .Carry(r4_carry),
    .Overflow(r4_ovf), .out_valid(r4_out_valid), .out_ready(r4_out_ready)
  );

  pipe_add_sub #(.WIDTH(32), .STAGES(1)) u_dut32s1 (
    .clk(clk), .rst(rst), .in_1(r_a), .in_2(r_b), .Cin(r_cin), .sub(r_sub),
    .in_valid(r1_in_valid), .in_ready(r1_in_ready), .Sum(r1_sum), .Carry(r1_carry),
    .Overflow(r1_ovf), .out_valid(r1_out_valid), .out_ready(r1_out_ready)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic done with plain integer maths.
  function automatic res_t golden(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sb);
    res_t r;
    logic [32:0] u;
    longint sa, sbv, s;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!sb) begin
      u = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r.carry = u[32];
      s = sa + sbv + (cin ? 64'sd1 : 64'sd0);
    end else begin
      u = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      r.carry = !u[32];
      s = sa - sbv - (cin ? 64'sd1 : 64'sd0);
    end
    r.sum = u[31:0];
    r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return r;
  endfunction

  // Send one vector into an empty 8-bit pipe. Count edges until the result
  // shows, then compare it.
  task automatic applyStimulus(input int idx, input vec_t v);
    int n;
    d_in_1 = v.a; d_in_2 = v.b; d_cin = v.cin; d_sub = v.sub;
    d_in_valid = 1'b1; d_out_ready = 1'b1;
    #1;
    checkOutput($sformatf("vec%0d_in_ready", idx), d_in_ready, 1);
    nextCycle();
    d_in_valid = 1'b0;
    n = 1;
    #1;
    while (!d_out_valid && n < 10) begin
      nextCycle();
      n++;
      #1;
    end
    checkOutput($sformatf("vec%0d_latency", idx), n, 2);
    checkOutput($sformatf("vec%0d_sum", idx), d_sum, v.sum);
    checkOutput($sformatf("vec%0d_carry", idx), d_carry, v.carry);
    checkOutput($sformatf("vec%0d_ovf", idx), d_ovf, v.ovf);
    nextCycle();
  endtask

  // Compare any result leaving a 32-bit instance with the head of its queue.
  task automatic checkStreams();
    res_t e;
    if (r4_out_valid && r4_out_ready) begin
      checkOutput("r4_spurious", 64'(q4.size() == 0), 0);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        checkOutput("r4_sum", r4_sum, e.sum);
        checkOutput("r4_carry", r4_carry, e.carry);
        checkOutput("r4_ovf", r4_ovf, e.ovf);
      end
    end
    if (r1_out_valid && r1_out_ready) begin
      checkOutput("r1_spurious", 64'(q1.size() == 0), 0);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        checkOutput("r1_sum", r1_sum, e.sum);
        checkOutput("r1_carry", r1_carry, e.carry);
        checkOutput("r1_ovf", r1_ovf, e.ovf);
      end
    end
  endtask

  // Main test sequence.
  initial begin
    int n_in, n_out, first_out, last_out, lat4, lat1, guard, spurious;
    logic p4, p1;
    res_t e;

    checks = 0; failures = 0;
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
    vecs[3] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1;
    d_in_1 = '0; d_in_2 = '0; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
    r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
    r4_in_valid = 1'b0; r4_out_ready = 1'b0; r1_in_valid = 1'b0; r1_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", d_out_valid, 0);
    checkOutput("reset_sum", d_sum, 0);
    checkOutput("reset_carry", d_carry, 0);
    checkOutput("reset_ovf", d_ovf, 0);
    checkOutput("reset_in_ready", d_in_ready, 1);
    nextCycle();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Backpressure: hold out_ready low while six operations are offered, then release.
    n_in = 0; n_out = 0; first_out = -1; last_out = -1;
    for (int cyc = 0; cyc < 40 && n_out < 6; cyc++) begin
      d_out_ready = (cyc >= 5);
      d_in_valid  = (n_in < 6);
      d_in_1 = 8'(n_in + 1); d_in_2 = 8'h10; d_cin = 1'b0; d_sub = 1'b0;
      #1;
      if (cyc >= 2 && cyc < 5) begin
        checkOutput("bp_in_ready_low", d_in_ready, 0);
        checkOutput("bp_hold_valid", d_out_valid, 1);
        checkOutput("bp_hold_sum", d_sum, 8'h11);
      end
      if (cyc == 4) checkOutput("bp_accepts", n_in, 2);
      if (d_out_valid && d_out_ready) begin
        checkOutput($sformatf("bp_order%0d", n_out), d_sum, 8'(8'h11 + n_out));
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      if (d_in_valid && d_in_ready) n_in++;
      nextCycle();
    end
    d_in_valid = 1'b0;
    checkOutput("bp_count", n_out, 6);
    checkOutput("bp_no_gaps", 64'(last_out - first_out), 5);

    // Reset with two operations in the pipe, while a third is offered during reset.
    d_out_ready = 1'b1; d_in_valid = 1'b1;
    d_in_1 = 8'hC0; d_in_2 = 8'h80;
    nextCycle();
    d_in_1 = 8'h7F; d_in_2 = 8'h01;
    nextCycle();
    d_out_ready = 1'b0; d_in_valid = 1'b0;
    #1;
    checkOutput("rst_pre_valid", d_out_valid, 1);
    checkOutput("rst_pre_sum", d_sum, 8'h40);
    rst = 1'b1; d_in_valid = 1'b1; d_in_1 = 8'h01; d_in_2 = 8'h01;
    nextCycle();
    rst = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b1;
    #1;
    checkOutput("rst_out_valid", d_out_valid, 0);
    checkOutput("rst_sum", d_sum, 0);
    checkOutput("rst_carry", d_carry, 0);
    checkOutput("rst_ovf", d_ovf, 0);
    checkOutput("rst_in_ready", d_in_ready, 1);
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      #1;
      if (d_out_valid) spurious++;
    end
    checkOutput("rst_discarded", spurious, 0);
    nextCycle();

    // Latency of the 32-bit instances with no stall.
    r_a = 32'h7FFF_FFFF; r_b = 32'h0000_0001; r_cin = 1'b0; r_sub = 1'b0;
    r4_in_valid = 1'b1; r1_in_valid = 1'b1; r4_out_ready = 1'b1; r1_out_ready = 1'b1;
    lat4 = 0; lat1 = 0;
    for (int n = 1; n <= 10 && (lat4 == 0 || lat1 == 0); n++) begin
      nextCycle();
      r4_in_valid = 1'b0; r1_in_valid = 1'b0;
      #1;
      if (r4_out_valid && lat4 == 0) begin
        lat4 = n;
        checkOutput("r4_lat_sum", r4_sum, 32'h8000_0000);
        checkOutput("r4_lat_ovf", r4_ovf, 1);
      end
      if (r1_out_valid && lat1 == 0) begin
        lat1 = n;
        checkOutput("r1_lat_sum", r1_sum, 32'h8000_0000);
        checkOutput("r1_lat_ovf", r1_ovf, 1);
      end
    end
    checkOutput("r4_latency", lat4, 4);
    checkOutput("r1_latency", lat1, 1);
    nextCycle();

    // Random add/sub stream with random out_ready on both 32-bit instances.
    for (int i = 0; i < 1000; i++) begin
      r_a = $urandom; r_b = $urandom;
      r_cin = 1'($urandom_range(0, 1)); r_sub = 1'($urandom_range(0, 1));
      e = golden(r_a, r_b, r_cin, r_sub);
      p4 = 1'b1; p1 = 1'b1; guard = 0;
      while ((p4 || p1) && guard < 100) begin
        r4_in_valid = p4; r1_in_valid = p1;
        r4_out_ready = ($urandom_range(0, 3) != 0);
        r1_out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (r4_in_valid && r4_in_ready) begin q4.push_back(e); p4 = 1'b0; end
        if (r1_in_valid && r1_in_ready) begin q1.push_back(e); p1 = 1'b0; end
        checkStreams();
        nextCycle();
        guard++;
      end
      if (p4 || p1) checkOutput("rand_accept", {p4, p1}, 0);
    end
    r4_in_valid = 1'b0; r1_in_valid = 1'b0; r4_out_ready = 1'b1; r1_out_ready = 1'b1;
    for (int i = 0; i < 50 && (q4.size() != 0 || q1.size() != 0); i++) begin
      #1;
      checkStreams();
      nextCycle();
    end
    checkOutput("r4_drained", q4.size(), 0);
    checkOutput("r1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
